gait_sequencer: RTL and testbench

GAIT_SEQUENCER -- requirements
Module: gait_sequencer

---
 rtl/gait_pkg.sv | 31 +++
 rtl/step_prescaler.sv | 29 ++
 rtl/gait_sequencer.sv | 141 ++++++++++++++
 tb/tb_gait_sequencer.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gait_pkg.sv
// Shared definitions for the gait sequencer: state encoding and step-divider
// speed selects.
package gait_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOMING = 2'd1,
    ST_RUN    = 2'd2,
    ST_PARK   = 2'd3
  } gait_state_t;

  localparam logic [1:0] SPEED_DIV1 = 2'd0;
  localparam logic [1:0] SPEED_DIV2 = 2'd1;
  localparam logic [1:0] SPEED_DIV4 = 2'd2;
  localparam logic [1:0] SPEED_DIV8 = 2'd3;

  localparam int DIV_W = 3;

  // Terminal divider count for a speed select: a step fires every 2^speed ticks.
  function automatic logic [DIV_W-1:0] div_limit(input logic [1:0] speed);
    logic [DIV_W-1:0] lim;
    case (speed)
      SPEED_DIV1: lim = 3'd0;
      SPEED_DIV2: lim = 3'd1;
      SPEED_DIV4: lim = 3'd3;
      default:    lim = 3'd7;
    endcase
    return lim;
  endfunction

endpackage

// File: rtl/step_prescaler.sv
// Base-rate prescaler: counts 0..P-1 and pulses tick for one cycle at P-1.
// Held at zero while clear is high.
module step_prescaler #(
  parameter int unsigned P = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);

  localparam int CNT_W = (P > 1) ? $clog2(P) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(P - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clear || (r_cnt == CNT_LAST)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign tick = !clear && (r_cnt == CNT_LAST);

endmodule

// File: rtl/gait_sequencer.sv
// Gait sequencer: homes the servos, then walks a gait-table index at a
// programmable step rate and parks on index 0 before halting.
//
//   state  | meaning
//   IDLE   | servos disabled at HOME, index 0, waiting for start
//   HOMING | servos disabled, dwelling for the homing time
//   RUN    | servos enabled, index stepping in the latched direction
//   PARK   | still stepping, halts once the index lands on 0
module gait_sequencer
  import gait_pkg::*;
#(
  parameter int unsigned CLK_HZ       = 12000000,
  parameter int unsigned STEP_HZ      = 40,
  parameter int unsigned ROM_SIZE     = 64,
  parameter int unsigned HOME_SECONDS = 7
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stop,
  input  logic       reverse,
  input  logic [1:0] speed,
  output logic [7:0] position,
  output logic       enable,
  output logic       step,
  output logic       cycle_done,
  output logic       busy
);

  localparam int unsigned P = CLK_HZ / STEP_HZ;
  localparam int unsigned H = HOME_SECONDS * CLK_HZ;
  localparam int HOME_W = (H > 1) ? $clog2(H) : 1;
  localparam logic [HOME_W-1:0] HOME_LAST = HOME_W'(H - 1);
  localparam logic [7:0] POS_LAST = 8'(ROM_SIZE - 1);

  gait_state_t       r_state, w_state_next;
  logic [7:0]        r_pos, w_pos_next;
  logic              r_dir, r_step, r_cycle_done;
  logic [DIV_W-1:0]  r_div;
  logic [HOME_W-1:0] r_home_cnt;
  logic              w_tick, w_active, w_clear, w_div_hit, w_step_now;
  logic              w_home_done, w_wrap;

  assign w_active = (r_state == ST_RUN) || (r_state == ST_PARK);
  assign w_clear  = !w_active;

  step_prescaler #(.P(P)) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (w_clear),
    .tick  (w_tick)
  );

  always_comb begin
    w_pos_next = r_pos;
    if (r_dir) begin
      w_pos_next = (r_pos == 8'd0) ? POS_LAST : r_pos - 8'd1;
    end else begin
      w_pos_next = (r_pos == POS_LAST) ? 8'd0 : r_pos + 8'd1;
    end
  end

  assign w_wrap      = (w_pos_next == 8'd0);
  assign w_div_hit   = w_tick && (r_div >= div_limit(speed));
  assign w_home_done = (r_home_cnt == HOME_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_step_now   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start && !stop) w_state_next = ST_HOMING;
      end
      ST_HOMING: begin
        if (stop)             w_state_next = ST_IDLE;
        else if (w_home_done) w_state_next = ST_RUN;
      end
      ST_RUN: begin
        w_step_now = w_div_hit;
        if (stop) w_state_next = ST_PARK;
      end
      ST_PARK: begin
        // Resuming keeps the running step cadence; it never adds a step.
        if (start && !stop) begin
          w_state_next = ST_RUN;
          w_step_now   = w_div_hit;
        end else if (r_pos == 8'd0) begin
          w_state_next = ST_IDLE;
        end else begin
          w_step_now = w_div_hit;
          if (w_div_hit && w_wrap) w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pos        <= 8'd0;
      r_dir        <= 1'b0;
      r_step       <= 1'b0;
      r_cycle_done <= 1'b0;
      r_div        <= '0;
      r_home_cnt   <= '0;
    end else begin
      r_step       <= w_step_now;
      r_cycle_done <= w_step_now && w_wrap;

      if ((r_state == ST_HOMING) && !stop && !w_home_done) r_home_cnt <= r_home_cnt + HOME_W'(1);
      else                                                 r_home_cnt <= '0;

      if (!w_active)   r_div <= '0;
      else if (w_tick) r_div <= w_div_hit ? '0 : r_div + DIV_W'(1);

      if (w_step_now) begin
        r_pos <= w_pos_next;
        if (w_wrap) r_dir <= reverse;
      end else if (!w_active) begin
        r_pos <= 8'd0;
      end

      if ((r_state == ST_HOMING) && (w_state_next == ST_RUN)) r_dir <= reverse;
    end
  end

  assign position   = r_pos;
  assign enable     = w_active;
  assign step       = r_step;
  assign cycle_done = r_cycle_done;
  assign busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_gait_sequencer.sv
// Bench for gait_sequencer: directed scenarios followed by random stimulus,
// all checked each cycle against a behavioural model of the walking rules.
module tb_gait_sequencer;

  localparam int CLK_HZ  = 100;
  localparam int STEP_HZ = 10;
  localparam int HOME_S  = 2;
  localparam int ROM     = 8;
  localparam int P       = CLK_HZ / STEP_HZ;
  localparam int H       = HOME_S * CLK_HZ;

  localparam int M_IDLE   = 0;
  localparam int M_HOMING = 1;
  localparam int M_RUN    = 2;
  localparam int M_PARK   = 3;

  logic       clk = 1'b0;
  logic       rst_n, start, stop, reverse;
  logic [1:0] speed;
  logic [7:0] position;
  logic       enable, step, cycle_done, busy;

  always #5 clk = ~clk;

  gait_sequencer #(
    .CLK_HZ       (CLK_HZ),
    .STEP_HZ      (STEP_HZ),
    .ROM_SIZE     (ROM),
    .HOME_SECONDS (HOME_S)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .stop       (stop),
    .reverse    (reverse),
    .speed      (speed),
    .position   (position),
    .enable     (enable),
    .step       (step),
    .cycle_done (cycle_done),
    .busy       (busy)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model: mode, walk index, latched direction, homing dwell,
  // cycles spent walking (base tick phase) and ticks since the last step.
  int m_mode, m_pos, m_dir, m_home, m_run_cyc, m_div;
  bit m_step, m_cd;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_pos = 0; m_dir = 0; m_home = 0;
    m_run_cyc = 0; m_div = 0; m_step = 0; m_cd = 0;
  endtask

  task automatic model_clock();
    bit walking, tick, hit, do_step;
    int nxt, lim, new_mode;
    walking  = (m_mode == M_RUN) || (m_mode == M_PARK);
    tick     = walking && ((m_run_cyc % P) == P - 1);
    lim      = (1 << speed) - 1;
    hit      = tick && (m_div >= lim);
    nxt      = m_dir ? (m_pos + ROM - 1) % ROM : (m_pos + 1) % ROM;
    do_step  = 0;
    new_mode = m_mode;
    case (m_mode)
      M_IDLE: if (start && !stop) begin new_mode = M_HOMING; m_home = 0; end
      M_HOMING: begin
        if (stop) new_mode = M_IDLE;
        else if (m_home == H - 1) begin new_mode = M_RUN; m_dir = reverse; end
        else m_home++;
      end
      M_RUN: begin do_step = hit; if (stop) new_mode = M_PARK; end
      default: begin
        if (start && !stop) begin new_mode = M_RUN; do_step = hit; end
        else if (m_pos == 0) new_mode = M_IDLE;
        else begin do_step = hit; if (hit && nxt == 0) new_mode = M_IDLE; end
      end
    endcase
    if (walking) begin
      m_run_cyc++;
      if (tick) m_div = hit ? 0 : m_div + 1;
    end
    m_step = do_step;
    m_cd   = do_step && (nxt == 0);
    if (do_step) begin
      m_pos = nxt;
      if (nxt == 0) m_dir = reverse;
    end
    if (new_mode == M_IDLE || new_mode == M_HOMING) begin
      m_run_cyc = 0; m_div = 0; m_pos = 0;
    end
    m_mode = new_mode;
  endtask

  task automatic compare_all();
    check("position", 32'(position), 32'(m_pos));
    check("enable", 32'(enable), 32'(m_mode == M_RUN || m_mode == M_PARK));
    check("busy", 32'(busy), 32'(m_mode != M_IDLE));
    check("step", 32'(step), 32'(m_step));
    check("cycle_done", 32'(cycle_done), 32'(m_cd));
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_clock();
      #1;
      compare_all();
    end
  endtask

  task automatic wait_step(output int n);
    n = 0;
    do begin
      cyc(1);
      n++;
    end while (!step && n < 500);
    check("step_seen", 32'(step), 32'd1);
  endtask

  task automatic home_and_check();
    int n;
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    check("busy_after_start", 32'(busy), 32'd1);
    n = 0;
    while (!enable && n < 300) begin
      cyc(1);
      n++;
    end
    check("homing_cycles", 32'(n), 32'(H));
    check("pos_after_homing", 32'(position), 32'd0);
  endtask

  initial begin
    int n;
    int exp_rev[8];
    exp_rev = '{4, 5, 6, 7, 0, 7, 6, 5};

    rst_n = 1'b0; start = 1'b0; stop = 1'b0; reverse = 1'b0; speed = 2'd0;
    model_reset();
    #12;
    compare_all();
    #10 rst_n = 1'b1;
    cyc(3);

    // Homing, then forward walk at speed 0 with 10-cycle spacing.
    home_and_check();
    for (int k = 1; k <= ROM; k++) begin
      wait_step(n);
      check("interval_speed0", 32'(n), 32'(P));
      check("fwd_position", 32'(position), 32'(k % ROM));
      check("fwd_cycle_done", 32'(cycle_done), 32'(k == ROM));
    end

    speed = 2'd2;
    for (int k = 1; k <= 2; k++) begin
      wait_step(n);
      check("interval_speed2", 32'(n), 32'(4 * P));
      check("slow_position", 32'(position), 32'(k));
    end

    // Reverse requested mid-cycle only takes effect at the wrap.
    speed = 2'd0;
    wait_step(n);
    check("pos_before_reverse", 32'(position), 32'd3);
    reverse = 1'b1;
    for (int k = 0; k < 8; k++) begin
      wait_step(n);
      check("rev_position", 32'(position), 32'(exp_rev[k]));
      check("rev_cycle_done", 32'(cycle_done), 32'(exp_rev[k] == 0));
    end

    // Back to forward (latched at next 0), then park from position 5.
    reverse = 1'b0;
    for (int k = 0; k < 10; k++) wait_step(n);
    check("pos_before_park", 32'(position), 32'd5);
    stop = 1'b1;
    wait_step(n); check("park_pos6", 32'(position), 32'd6);
    wait_step(n); check("park_pos7", 32'(position), 32'd7);
    wait_step(n); check("park_pos0", 32'(position), 32'd0);
    check("park_cycle_done", 32'(cycle_done), 32'd1);
    cyc(1);
    check("park_enable_low", 32'(enable), 32'd0);
    check("park_idle", 32'(busy), 32'd0);

    // Start and stop together in IDLE: stop wins.
    start = 1'b1;
    cyc(3);
    check("start_stop_idle", 32'(busy), 32'd0);
    start = 1'b0; stop = 1'b0;
    cyc(2);

    // Asynchronous reset in RUN at position 4.
    home_and_check();
    for (int k = 0; k < 4; k++) wait_step(n);
    check("pos_before_reset", 32'(position), 32'd4);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_position", 32'(position), 32'd0);
    check("async_rst_enable", 32'(enable), 32'd0);
    check("async_rst_busy", 32'(busy), 32'd0);
    check("async_rst_step", 32'(step), 32'd0);
    model_reset();
    #20 rst_n = 1'b1;
    cyc(2);
    home_and_check();

    stop = 1'b1;
    n = 0;
    while (busy && n < 200) begin
      cyc(1);
      n++;
    end
    check("park_to_idle", 32'(busy), 32'd0);
    stop = 1'b0;
    cyc(2);

    // Stop partway through homing, then a full homing again.
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(99);
    stop = 1'b1;
    cyc(1);
    check("homing_abort", 32'(busy), 32'd0);
    stop = 1'b0;
    cyc(2);
    home_and_check();

    // Random stimulus against the model.
    for (int i = 0; i < 4000; i++) begin
      start = ($urandom_range(0, 29) == 0);
      stop  = ($urandom_range(0, 399) == 0);
      if ($urandom_range(0, 29) == 0) reverse = ~reverse;
      if ($urandom_range(0, 49) == 0) speed = 2'($urandom_range(0, 3));
      cyc(1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
